// File: rtl/fpu_add_pkg.sv
// Shared types and constants for the FP32 adder issue arbiter slice.
//   FP32_W       operand/result width (IEEE-754 single)
//   FLAG_W       adder status flag width {ovf, underflow, inexact, invalid, zero}
//   ADD_LATENCY  register depth of the shared adder
//   owner_e      which requester an operation belongs to
//   rsp_data_t   adder result payload carried through the response FIFO
package fpu_add_pkg;

  localparam int FP32_W      = 32;
  localparam int FLAG_W      = 5;
  localparam int ADD_LATENCY = 18;

  // Bit positions inside the adder flag vector
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_INVALID = 1;
  localparam int FLAG_INEXACT = 2;
  localparam int FLAG_UNDER   = 3;
  localparam int FLAG_OVF     = 4;

  typedef enum logic {
    OWNER_0 = 1'b0,
    OWNER_1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic [FP32_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } rsp_data_t;

  // The round-robin pointer always moves to the requester that was not served
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_0) ? OWNER_1 : OWNER_0;
  endfunction

endpackage

// File: rtl/fpu_add_rsp_fifo.sv
// Synchronous result FIFO holding adder results until the owning requester
// accepts them. Registered read/write pointers with a wrap bit, no bypass:
// a pushed entry becomes visible at the head the cycle after the push.
//   clk, rst    clock / asynchronous active-high reset (empties the FIFO)
//   push        write push_data this cycle
//   push_data   entry to store
//   pop         retire the head entry this cycle
//   head_data   current head entry (meaningless while empty)
//   empty/full  occupancy status
module fpu_add_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty can be told apart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fpu_add_issue_arbiter.sv
// Shares one pipelined FP32 adder between two requesters.
// Round-robin issue (one op per cycle), a shadow pipeline matched to the adder
// latency that carries owner/tag alongside each op, and a credit-gated result
// FIFO so the non-stallable adder never loses a result under backpressure.
//   clk, rst                 clock / asynchronous active-high reset
//   reqN_valid/ready         operation handshake from requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_sub operands and subtract select
//   reqN_tag                 opaque tag returned with the result
//   add_valid/a/b/sub        registered operation presented to the adder
//   add_res, add_flags       adder result, LATENCY cycles after add_valid
//   rspN_valid/ready         result handshake to requester N
//   rspN_data/flags/tag      result, flags and originating tag
module fpu_add_issue_arbiter
  import fpu_add_pkg::*;
#(
  parameter int LATENCY = ADD_LATENCY,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [FP32_W-1:0] req0_a,
  input  logic [FP32_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [FP32_W-1:0] req1_a,
  input  logic [FP32_W-1:0] req1_b,
  input  logic              req1_sub,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              add_valid,
  output logic [FP32_W-1:0] add_a,
  output logic [FP32_W-1:0] add_b,
  output logic              add_sub,
  input  logic [FP32_W-1:0] add_res,
  input  logic [FLAG_W-1:0] add_flags,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [FP32_W-1:0] rsp0_data,
  output logic [FLAG_W-1:0] rsp0_flags,
  output logic [TAG_W-1:0]  rsp0_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [FP32_W-1:0] rsp1_data,
  output logic [FLAG_W-1:0] rsp1_flags,
  output logic [TAG_W-1:0]  rsp1_tag
);

  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic             valid;
    owner_e           owner;
    logic [TAG_W-1:0] tag;
  } shadow_t;

  typedef struct packed {
    owner_e           owner;
    logic [TAG_W-1:0] tag;
    rsp_data_t        rsp;
  } rsp_entry_t;

  localparam int ENTRY_W = $bits(rsp_entry_t);

  logic             active;
  owner_e           rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             can_issue;
  logic             grant0;
  logic             grant1;
  logic             grant_any;
  shadow_t          shadow [LATENCY+1];
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;

  // A pop in the same cycle frees a slot, so issue may proceed even at a full
  // credit count; this lets issue resume in the very cycle backpressure lifts.
  // 'active' keeps both ready outputs low while reset is asserted.
  assign fifo_pop  = !fifo_empty &&
                     ((head_entry.owner == OWNER_1) ? rsp1_ready : rsp0_ready);
  assign can_issue = active && ((cnt < DEPTH_C) || fifo_pop);

  // Round-robin: the pointed requester wins if valid, otherwise the other one
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_issue) begin
      if (rr_ptr == OWNER_0) begin
        if (req0_valid)      grant0 = 1'b1;
        else if (req1_valid) grant1 = 1'b1;
      end else begin
        if (req1_valid)      grant1 = 1'b1;
        else if (req0_valid) grant0 = 1'b1;
      end
    end
  end

  assign grant_any  = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Registered adder interface and pointer update; the pointer only moves on a grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      rr_ptr    <= OWNER_0;
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_sub   <= 1'b0;
    end else begin
      active    <= 1'b1;
      add_valid <= grant_any;
      if (grant0) begin
        add_a   <= req0_a;
        add_b   <= req0_b;
        add_sub <= req0_sub;
        rr_ptr  <= other_owner(OWNER_0);
      end else if (grant1) begin
        add_a   <= req1_a;
        add_b   <= req1_b;
        add_sub <= req1_sub;
        rr_ptr  <= other_owner(OWNER_1);
      end
    end
  end

  // Credits count ops in flight plus ops parked in the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({grant_any, fifo_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Shadow pipe: stage 0 loads alongside add_valid, so the last stage lines up
  // with add_res LATENCY cycles later. Clearing it on reset discards stale results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LATENCY; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      shadow[0].valid <= grant_any;
      shadow[0].owner <= grant1 ? OWNER_1 : OWNER_0;
      shadow[0].tag   <= grant1 ? req1_tag : req0_tag;
      for (int i = 1; i <= LATENCY; i++) begin
        shadow[i] <= shadow[i-1];
      end
    end
  end

  always_comb begin
    push_entry           = '0;
    push_entry.owner     = shadow[LATENCY].owner;
    push_entry.tag       = shadow[LATENCY].tag;
    push_entry.rsp.data  = add_res;
    push_entry.rsp.flags = add_flags;
  end

  assign fifo_push = shadow[LATENCY].valid;

  fpu_add_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_bits),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_entry = rsp_entry_t'(head_bits);

  // Only the owner of the head entry sees a valid response
  assign rsp0_valid = !fifo_empty && (head_entry.owner == OWNER_0);
  assign rsp1_valid = !fifo_empty && (head_entry.owner == OWNER_1);
  assign rsp0_data  = head_entry.rsp.data;
  assign rsp0_flags = head_entry.rsp.flags;
  assign rsp0_tag   = head_entry.tag;
  assign rsp1_data  = head_entry.rsp.data;
  assign rsp1_flags = head_entry.rsp.flags;
  assign rsp1_tag   = head_entry.tag;

  // Credits make a push into a full FIFO impossible; catch it if that ever breaks
  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));
  assert property (@(posedge clk) disable iff (rst) cnt <= DEPTH_C);

endmodule

// File: tb/tb_fpu_add_issue_arbiter.sv
// Scoreboard bench for fpu_add_issue_arbiter with a behavioural adder model.
module tb_fpu_add_issue_arbiter;

  localparam int LAT   = 18;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int STIM_BUDGET = 200;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] data;
    logic [4:0]  flags;
  } vec_t;

  typedef struct {
    int               owner;
    logic [31:0]      data;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
    int               issueCycle;
    bit               checkLat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req0_sub;
  logic [31:0]       req0_a, req0_b;
  logic [TAG_W-1:0]  req0_tag;
  logic              req1_valid, req1_ready, req1_sub;
  logic [31:0]       req1_a, req1_b;
  logic [TAG_W-1:0]  req1_tag;
  logic              add_valid, add_sub;
  logic [31:0]       add_a, add_b, add_res;
  logic [4:0]        add_flags;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0]       rsp0_data, rsp1_data;
  logic [4:0]        rsp0_flags, rsp1_flags;
  logic [TAG_W-1:0]  rsp0_tag, rsp1_tag;

  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  int   rspSeen  = 0;
  bit   headSeen = 0;
  exp_t expQ[$];
  int   grantLog[$];
  int   issueLog[$];
  int   popLog[$];

  logic [31:0] resPipe  [LAT];
  logic [4:0]  flagPipe [LAT];

  fpu_add_issue_arbiter #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_tag(req1_tag),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_res(add_res), .add_flags(add_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_flags(rsp0_flags), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_flags(rsp1_flags), .rsp1_tag(rsp1_tag)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Directed vectors with hand-computed IEEE-754 results and flags
  function automatic vec_t getVec(input int i);
    vec_t v;
    case (i)
      0:       v = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000}; //  1+2 = 3
      1:       v = '{32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000, 5'b00001}; //  5-5 = 0
      2:       v = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'b00000}; //  1+1 = 2
      3:       v = '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5'b00000}; //  2+2 = 4
      4:       v = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5'b00000}; //  3-1 = 2
      5:       v = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 5'b00000}; //  1-2 = -1
      6:       v = '{32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 5'b00000}; //  4+1 = 5
      default: v = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 5'b00000}; //  2-1 = 1
    endcase
    return v;
  endfunction

  // Adder stand-in: knows the directed operand pairs, anything else yields a quiet NaN
  function automatic logic [36:0] adderModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic sub);
    logic [36:0] r;
    r = {32'h7FC00000, 5'b00010};
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = getVec(i);
      if (v.a == a && v.b == b && v.sub == sub) r = {v.data, v.flags};
    end
    return r;
  endfunction

  // Free-running, never reset, so stale results keep arriving after a DUT reset
  always @(posedge clk) begin
    {resPipe[0], flagPipe[0]} <= adderModel(add_a, add_b, add_sub);
    for (int i = 1; i < LAT; i++) begin
      resPipe[i]  <= resPipe[i-1];
      flagPipe[i] <= flagPipe[i-1];
    end
  end
  assign add_res   = resPipe[LAT-1];
  assign add_flags = flagPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Hold a request until accepted; the expected response enters the scoreboard on acceptance
  task automatic applyStimulus(input int port, input int vi, input logic [TAG_W-1:0] tag,
                               input bit chkLat);
    vec_t v;
    exp_t e;
    bit   accepted;
    v = getVec(vi);
    accepted = 0;
    if (port == 0) begin
      req0_a = v.a; req0_b = v.b; req0_sub = v.sub; req0_tag = tag; req0_valid = 1'b1;
    end else begin
      req1_a = v.a; req1_b = v.b; req1_sub = v.sub; req1_tag = tag; req1_valid = 1'b1;
    end
    for (int i = 0; i < STIM_BUDGET; i++) begin
      @(negedge clk);
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
        accepted = 1;
        e = '{port, v.data, v.flags, tag, cycle, chkLat};
        expQ.push_back(e);
        grantLog.push_back(port);
        issueLog.push_back(cycle);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout port=%0d actual=not_accepted expected=accepted", port);
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain actual=%0d_pending expected=0_pending", name, expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares the scoreboard head against whatever response the DUT presents
  initial forever begin
    exp_t h;
    logic [31:0] d;
    logic [4:0]  f;
    logic [TAG_W-1:0] t;
    @(negedge clk);
    if (!rst && (rsp0_valid || rsp1_valid)) begin
      rspSeen++;
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp actual=rsp0:%0b,rsp1:%0b expected=none",
                 rsp0_valid, rsp1_valid);
      end else begin
        h = expQ[0];
        if (!headSeen) begin
          headSeen = 1;
          checks++;
          if (rsp0_valid !== (h.owner == 0) || rsp1_valid !== (h.owner == 1)) begin
            failures++;
            $display("[TB] FAIL rsp_owner actual=rsp0:%0b,rsp1:%0b expected_owner=%0d",
                     rsp0_valid, rsp1_valid, h.owner);
          end
          if (h.checkLat) begin
            checks++;
            if (cycle - h.issueCycle != LAT + 2) begin
              failures++;
              $display("[TB] FAIL rsp_latency actual=%0d expected=%0d",
                       cycle - h.issueCycle, LAT + 2);
            end
          end
        end
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          d = rsp1_valid ? rsp1_data  : rsp0_data;
          f = rsp1_valid ? rsp1_flags : rsp0_flags;
          t = rsp1_valid ? rsp1_tag   : rsp0_tag;
          checkOutput("rsp_data", d, h.data);
          checkOutput("rsp_flags", 32'(f), 32'(h.flags));
          checkOutput("rsp_tag", 32'(t), 32'(h.tag));
          void'(expQ.pop_front());
          popLog.push_back(cycle);
          headSeen = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int popBase;
    int seenBase;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0; req0_tag = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0; req1_tag = '0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset state, with requests already pending
    idle(2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    checkOutput("reset_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("reset_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("reset_add_valid", 32'(add_valid), 32'd0);
    checkOutput("reset_add_a", add_a, 32'd0);
    checkOutput("reset_add_b", add_b, 32'd0);
    checkOutput("reset_add_sub", 32'(add_sub), 32'd0);
    checkOutput("reset_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    idle(2);

    $display("[TB] single op on requester 0");
    applyStimulus(0, 0, 4'd3, 1'b1);
    waitDrain("single", 60);

    $display("[TB] ownership: requester 1 subtract to zero");
    applyStimulus(1, 1, 4'd9, 1'b1);
    waitDrain("ownership", 60);

    $display("[TB] reset with ops in flight");
    applyStimulus(1, 4, 4'd1, 1'b0);
    applyStimulus(0, 2, 4'd2, 1'b0);
    applyStimulus(0, 3, 4'd3, 1'b0);
    idle(5);
    rst = 1'b1;
    expQ.delete();
    headSeen = 0;
    seenBase = rspSeen;
    idle(1);
    rst = 1'b0;
    idle(40);
    checkOutput("reset_no_rsp", 32'(rspSeen - seenBase), 32'd0);

    $display("[TB] fairness with both requesters valid");
    grantLog.delete();
    base = issueLog.size();
    fork
      begin
        applyStimulus(0, 2, 4'd0, 1'b0);
        applyStimulus(0, 3, 4'd1, 1'b0);
        applyStimulus(0, 4, 4'd2, 1'b0);
        applyStimulus(0, 5, 4'd3, 1'b0);
      end
      begin
        applyStimulus(1, 6, 4'd8, 1'b0);
        applyStimulus(1, 7, 4'd9, 1'b0);
        applyStimulus(1, 0, 4'd10, 1'b0);
        applyStimulus(1, 2, 4'd11, 1'b0);
      end
    join
    checkOutput("fair_grant_count", 32'(grantLog.size()), 32'd8);
    for (int i = 0; i < grantLog.size(); i++) begin
      checkOutput($sformatf("fair_grant%0d", i), 32'(grantLog[i]), 32'(i % 2));
    end
    checkOutput("fair_back_to_back", 32'(issueLog[base+1] - issueLog[base]), 32'd1);
    waitDrain("fairness", 100);

    $display("[TB] backpressure on requester 0");
    rsp0_ready = 1'b0;
    base = issueLog.size();
    popBase = popLog.size();
    fork
      begin
        applyStimulus(0, 2, 4'd4, 1'b0);
        applyStimulus(0, 3, 4'd5, 1'b0);
        applyStimulus(0, 4, 4'd6, 1'b0);
        applyStimulus(0, 5, 4'd7, 1'b0);
        applyStimulus(0, 6, 4'd8, 1'b0);
        applyStimulus(0, 7, 4'd9, 1'b0);
      end
    join_none
    idle(40);
    checkOutput("bp_accepted", 32'(issueLog.size() - base), 32'd4);
    @(negedge clk);
    checkOutput("bp_req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    wait fork;
    waitDrain("backpressure", 100);
    checkOutput("bp_resume_on_pop", 32'(issueLog[base+4]), 32'(popLog[popBase]));

    $display("[TB] grant and pop together one below full");
    rsp0_ready = 1'b0;
    applyStimulus(0, 2, 4'd1, 1'b0);
    applyStimulus(0, 3, 4'd2, 1'b0);
    applyStimulus(0, 4, 4'd3, 1'b0);
    idle(25);
    base = issueLog.size();
    popBase = popLog.size();
    fork
      begin
        applyStimulus(1, 5, 4'd12, 1'b0);
        applyStimulus(1, 6, 4'd13, 1'b0);
        applyStimulus(1, 7, 4'd14, 1'b0);
      end
    join_none
    rsp0_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp0_ready = 1'b0;
    idle(30);
    checkOutput("simul_accepted", 32'(issueLog.size() - base), 32'd2);
    checkOutput("simul_same_cycle", 32'(issueLog[base]), 32'(popLog[popBase]));
    rsp0_ready = 1'b1;
    wait fork;
    waitDrain("simultaneous", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
